// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: buffered valid/ready input, LSB-first frames with optional parity.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-word FIFO; otherwise a single holding register is used.
module uart_tx_param #(
  parameter int CLK_FREQ    = 6000000,
  parameter int BAUD_RATE   = 600000,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       baud_cnt_reg, baud_cnt_next;
  logic [3:0]             bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   parity_reg, parity_next;
  logic                   tx_reg, tx_next;
  logic                   busy_reg, busy_next;

  logic                   fifo_empty;
  logic                   fifo_full;
  logic [DATA_BITS-1:0]   head_word;
  logic                   push;
  logic                   pop;
  logic                   bit_done;
  logic                   last_data;
  logic                   last_stop;

  // Ready is forced low while reset is held, otherwise it follows the registered level.
  assign data_ready = reset_n && !fifo_full;
  assign push       = data_valid && data_ready;

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [LVL_W-1:0]     level_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign head_word  = mem[rd_ptr_reg];
  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == LVL_W'(FIFO_DEPTH));
  assign fifo_level = level_reg;
`else
  logic [DATA_BITS-1:0] hold_reg;
  logic                 hold_valid_reg;

  // Push needs an empty register and pop a full one, so they never coincide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
    end else if (push) begin
      hold_reg       <= data_in;
      hold_valid_reg <= 1'b1;
    end else if (pop) begin
      hold_valid_reg <= 1'b0;
    end
  end

  assign head_word  = hold_reg;
  assign fifo_empty = !hold_valid_reg;
  assign fifo_full  = hold_valid_reg;
  assign fifo_level = LVL_W'(hold_valid_reg);
`endif

  assign bit_done  = (baud_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
  assign last_data = (bit_cnt_reg == 4'(DATA_BITS - 1));
  assign last_stop = (bit_cnt_reg == 4'(STOP_BITS - 1));
  assign pop       = !fifo_empty &&
                     ((state_reg == IDLE) || (state_reg == STOP && bit_done && last_stop));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (!fifo_empty) state_next = START;
      START:  if (bit_done) state_next = DATA;
      DATA:   if (bit_done && last_data) state_next = (PARITY_MODE != 0) ? PARITY : STOP;
      PARITY: if (bit_done) state_next = STOP;
      STOP:   if (bit_done && last_stop) state_next = fifo_empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    baud_cnt_next = baud_cnt_reg + 1'b1;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    tx_next       = tx_reg;
    busy_next     = (state_next != IDLE);

    if (pop || bit_done || state_reg == IDLE) baud_cnt_next = '0;

    if (pop || state_next != state_reg) bit_cnt_next = '0;
    else if (bit_done)                  bit_cnt_next = bit_cnt_reg + 1'b1;

    if (pop) begin
      shift_next  = head_word;
      parity_next = (PARITY_MODE == 2) ? ~^head_word : ^head_word;
    end else if (state_reg == DATA && bit_done) begin
      shift_next = shift_reg >> 1;
    end

    // Line value for the next cycle; within DATA the bit after a shift is shift_reg[1].
    case (state_next)
      IDLE:   tx_next = 1'b1;
      START:  tx_next = 1'b0;
      DATA:   begin
        if (state_reg == START) tx_next = shift_reg[0];
        else if (bit_done)      tx_next = shift_reg[1];
      end
      PARITY: tx_next = parity_reg;
      STOP:   tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

  assign tx      = tx_reg;
  assign tx_busy = busy_reg;

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with a transmit FIFO, configurable frame format and exact baud timing. It accepts words over a valid/ready handshake, buffers them, and serialises them back-to-back on `tx`. It is the drop-in transmit side for the inter-FPGA serial links, and it replaces the fixed 8-bit, single-word transmitter wherever burst traffic or non-8E1 framing is needed.

## Interface
- `CLK_FREQ`, 6000000, system clock frequency in Hz
- `BAUD_RATE`, 600000, line rate; `CLKS_PER_BIT = CLK_FREQ/BAUD_RATE` (integer division), must be ≥ 2
- `DATA_BITS`, 8, payload width, legal range 5..9
- `PARITY_MODE`, 1, 0 = none, 1 = even, 2 = odd
- `STOP_BITS`, 1, 1 or 2
- `FIFO_DEPTH`, 8, power of two ≥ 2; used only when the FIFO is compiled in
- `clk`  in  1  system clock; all logic on its rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `data_in`  in  DATA_BITS  word to transmit
- `data_valid`  in  1  `data_in` is valid this cycle
- `data_ready`  out  1  block can accept a word this cycle
- `tx`  out  1  serial line, idle high
- `tx_busy`  out  1  a frame is on the line
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of words buffered

## Operation
- Reset (`reset_n` low) sets `tx`=1, `tx_busy`=0 and `fifo_level`=0, clears the FIFO and puts the FSM in IDLE. `data_ready` is 0 while reset is asserted and 1 on the first cycle after release.
- Accept occurs when `data_valid && data_ready` at a rising edge. `data_ready = !fifo_full`, combinational from the registered level. Pushes while full cannot occur, and the word is not captured.
- Frame, LSB first: START(0), DATA_BITS data, optional parity, STOP_BITS × 1.
- Parity is computed over the popped word: even gives `^word`, odd gives `~^word`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. The word is popped into the shift register, and `tx` is set to 0 on the same edge.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY, or → STOP when PARITY_MODE=0, after DATA_BITS bit periods.
  - PARITY → STOP after 1 bit period.
  - STOP lasts STOP_BITS bit periods. On completion the FSM goes to START with an immediate pop if the FIFO is non-empty, or to IDLE otherwise.
- Baud counter: 0..CLKS_PER_BIT-1, reset at each bit boundary. Every bit is exactly CLKS_PER_BIT cycles.
- A push and a pop on the same edge leave `fifo_level` unchanged. The read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Latency: a word accepted at edge N into an empty FIFO while IDLE drives `tx` low at edge N+1.
- `tx_busy` rises with the start bit and falls on the edge that ends the final stop bit. Back-to-back frames keep `tx_busy` high with no idle cycles between them.
- Frame length is (1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- A word pushed while the FIFO is full and a pop is happening is not accepted, because `data_ready` was 0. `data_ready` rises the cycle after the pop.
- Reset asserted mid-frame forces `tx`=1 immediately (asynchronous). The frame is aborted and the FIFO contents are discarded.
- `tx`, `tx_busy` and `fifo_level` are all registered outputs.

## Configuration
- `UART_TX_FIFO_EN` defined: a FIFO of FIFO_DEPTH words is instantiated.
- `UART_TX_FIFO_EN` undefined: a single holding register is used, with an effective depth of 1 and `fifo_level` of 0 or 1.
  - `data_ready` is high only when the holding register is empty.
  - The register is loaded on accept and emptied on the IDLE→START or STOP→START pop.
  - Timing and framing are otherwise identical.

## Test plan
- Default parameters (10 clk/bit, 8E1), push 0xA5 once.
  - `tx` sequence is 0,1,0,1,0,0,1,0,1,0,1, each bit 10 cycles.
  - `tx` goes low 1 cycle after accept.
  - `tx_busy` is high for 110 cycles.
- PARITY_MODE=2, push 0x01 → parity bit 0. Repeat with PARITY_MODE=1 → parity bit 1. Repeat with PARITY_MODE=0 → no parity bit, 100-cycle frame.
- DATA_BITS=7, STOP_BITS=2, push 0x7F → 0, then seven 1s, parity 1 (even), two stop bits; 110-cycle frame.
- FIFO_DEPTH=8, hold `data_valid` high with 10 distinct words.
  - `data_ready` drops when `fifo_level`=8.
  - All 10 words are transmitted in order with zero idle cycles between frames.
  - `tx_busy` stays high throughout.
- Push 0x55 and assert `reset_n` low at cycle 35 of the frame.
  - `tx`=1, `tx_busy`=0 and `fifo_level`=0 immediately.
  - After release, the next push transmits normally.
- Build without `UART_TX_FIFO_EN` and push 2 words back-to-back.
  - The second word waits with `data_ready` low until the first word's start edge.
  - The second frame follows the first stop bit with no idle gap.
